key_debounce_bank: RTL and testbench



---
 rtl/key_debounce_bank.sv | 130 +++++++++++++
 tb/tb_key_debounce_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_bank
// Description : Debounces a bank of raw mechanical key inputs. A shared
//               prescaler generates a sample tick. On each tick, a per-key
//               saturating counter tracks how many consecutive ticks the
//               sampled level has differed from the debounced state. When
//               that count reaches DB_COUNT, the key flips. A single pulse
//               flags any change in the debounced vector.
// Parameters  : NUM_KEYS - number of independent keys (>=1)
//               TICK_DIV - clk_i cycles per sample tick (>=1)
//               DB_COUNT - consecutive differing ticks to flip a key (>=1)
// Ports       : clk_i          in  1        fabric clock, rising edge
//               rst_i          in  1        synchronous reset, active-high
//               keys_i         in  NUM_KEYS raw key levels, 1 = pressed
//               keys_o         out NUM_KEYS debounced key state, registered
//               keys_changed_o out 1        one-cycle pulse on any keys_o change
// Option      : define KEYS_SYNC_EN to pass keys_i through a 2-flop
//               synchronizer before sampling (+2 cycles input latency).
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_bank #(
    parameter int NUM_KEYS = 61,
    parameter int TICK_DIV = 470,
    parameter int DB_COUNT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                keys_changed_o
);

    // Prescaler needs at least one bit even when TICK_DIV == 1.
    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CW = $clog2(DB_COUNT + 1);

    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE  = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(DB_COUNT - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX    = c_CW'(DB_COUNT);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic            w_tick;

    // With TICK_DIV == 1 the prescaler is stuck at 0 == c_PRESC_LAST,
    // so every non-reset cycle is a tick.
    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Input sampling path
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] w_sample;

`ifdef KEYS_SYNC_EN
    logic [NUM_KEYS-1:0] r_sync_meta;
    logic [NUM_KEYS-1:0] r_sync_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync_meta <= '0;
            r_sync_out  <= '0;
        end else begin
            r_sync_meta <= keys_i;
            r_sync_out  <= r_sync_meta;
        end
    end

    assign w_sample = r_sync_out;
`else
    assign w_sample = keys_i;
`endif

    // ------------------------------------------------------------------
    // Per-key debounce counters
    // ------------------------------------------------------------------
    logic [c_CW-1:0]     r_cnt     [NUM_KEYS];
    logic [c_CW-1:0]     w_cnt_nxt [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_keys_nxt;

    always_comb begin
        w_keys_nxt = keys_o;
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            if (w_tick) begin
                if (w_sample[k] == keys_o[k]) begin
                    // Any agreement with the current state restarts the count.
                    w_cnt_nxt[k] = '0;
                end else if (r_cnt[k] == c_CNT_LAST) begin
                    w_keys_nxt[k] = w_sample[k];
                    w_cnt_nxt[k]  = '0;
                end else if (r_cnt[k] != c_CNT_MAX) begin
                    // Saturating increment; never wraps.
                    w_cnt_nxt[k] = r_cnt[k] + c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_cnt[k] <= '0;
            end
            keys_o         <= '0;
            keys_changed_o <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            keys_o         <= w_keys_nxt;
            // One pulse no matter how many keys flip together.
            keys_changed_o <= (w_keys_nxt != keys_o);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_bank
// Description : Self-checking bench for key_debounce_bank with NUM_KEYS=8,
//               TICK_DIV=4, DB_COUNT=3. Cycle 0 is the first cycle after
//               reset release; ticks fall on cycles 3, 7, 11, ...
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_bank;

    localparam int NK = 8;
    localparam int TD = 4;
    localparam int DC = 3;
    localparam int c_NVEC = 86;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [NK-1:0] keys_in = '0;
    logic [NK-1:0] keys_out;
    logic          chg;

    int n_vec = 0;
    int n_err = 0;

    key_debounce_bank #(
        .NUM_KEYS (NK),
        .TICK_DIV (TD),
        .DB_COUNT (DC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .keys_i         (keys_in),
        .keys_o         (keys_out),
        .keys_changed_o (chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        logic [7:0] kin;
        logic [7:0] exp_keys;
        logic       exp_chg;
    } vec_t;

    vec_t tbl [c_NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int cyc,
                       input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, got, exp);
        end
    endtask

    // Leaves rst low at the start of cycle 0.
    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int  cyc;
        logic bnc;

        // Phase A: press key0 at cycle 0 (flip visible at 12), release from
        // cycle 12 (ticks 15,19,23 -> release visible at 24).
        for (int i = 0; i < 26; i++) begin
            tbl[i].do_rst   = (i == 0);
            tbl[i].kin      = (i < 12) ? 8'h01 : 8'h00;
            tbl[i].exp_keys = (i >= 12 && i < 24) ? 8'h01 : 8'h00;
            tbl[i].exp_chg  = (i == 12 || i == 24);
        end
        // Phase B: key1 bounces high,high,low per tick window for 15 ticks
        // while keys 6 and 7 press together and flip in one pulse at 12.
        for (int j = 0; j < 60; j++) begin
            bnc                  = (((j / 4) % 3) != 2);
            tbl[26 + j].do_rst   = (j == 0);
            tbl[26 + j].kin      = {2'b11, 4'b0000, bnc, 1'b0};
            tbl[26 + j].exp_keys = (j >= 12) ? 8'hC0 : 8'h00;
            tbl[26 + j].exp_chg  = (j == 12);
        end

        // Test 1: reset held with all keys pressed.
        keys_in = 8'hFF;
        rst     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_keys", i, keys_out, 8'h00);
            chk("reset_chg", i, {7'b0, chg}, 8'h00);
        end

        // Table-driven phases.
        cyc = 0;
        for (int i = 0; i < c_NVEC; i++) begin
            if (tbl[i].do_rst) begin
                keys_in = 8'h00;
                pulse_reset(2);
                cyc = 0;
            end
            keys_in = tbl[i].kin;
            chk((i < 26) ? "press_rel_keys" : "bounce_keys", cyc, keys_out, tbl[i].exp_keys);
            chk((i < 26) ? "press_rel_chg" : "bounce_chg", cyc, {7'b0, chg}, {7'b0, tbl[i].exp_chg});
            step();
            cyc++;
        end

        // Test 5: reset after two ticks of progress discards the count.
        keys_in = 8'h00;
        pulse_reset(2);
        keys_in = 8'h04;
        for (int c = 0; c < 8; c++) begin
            chk("midrst_pre_keys", c, keys_out, 8'h00);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            chk("midrst_keys", c, keys_out, (c >= 12) ? 8'h04 : 8'h00);
            chk("midrst_chg", c, {7'b0, chg}, (c == 12) ? 8'h01 : 8'h00);
            step();
        end

`ifdef KEYS_SYNC_EN
        // Input arriving at cycle 2 misses the tick at cycle 3 through the
        // synchronizer, so the flip lands at cycle 16.
        keys_in = 8'h00;
        pulse_reset(2);
        for (int c = 0; c <= 17; c++) begin
            keys_in = (c >= 2) ? 8'h01 : 8'h00;
            chk("sync_late_keys", c, keys_out, (c >= 16) ? 8'h01 : 8'h00);
            chk("sync_late_chg", c, {7'b0, chg}, (c == 16) ? 8'h01 : 8'h00);
            step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
